scaled_mul_pipe: RTL

- Pipelined fixed-point multiply, scale and resize stage; sits directly downstream of the operand-cast logic and consumes its cast operands.
- Each operand is widened to the full product width, following its own signedness, before multiplying, so the product never loses bits.
- The product is shifted right by a fixed amount, then resized to the output width by truncation or saturation.
- Valid/ready stream on both sides; 2-stage pipeline; 1 result per cycle.

---
 rtl/scaled_mul_pipe.sv | 128 ++++++++++++
 1 files changed

// File: rtl/scaled_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module   : scaled_mul_pipe
// Brief    : Two-stage multiply, scale and resize (truncate/saturate) with
//            valid/ready handshake on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module scaled_mul_pipe #(
    parameter int A_W      = 8,
    parameter int B_W      = 8,
    parameter int OUT_W    = 8,
    parameter int SHIFT    = 8,
    parameter int SIGNED_A = 0,
    parameter int SIGNED_B = 0,
    parameter int SAT      = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [A_W-1:0]   in_a,
    input  logic [B_W-1:0]   in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf
);

    localparam int              c_pw     = A_W + B_W;
    localparam bit              c_signed = (SIGNED_A != 0) || (SIGNED_B != 0);
    localparam bit              c_sat    = (SAT != 0);
    localparam logic [OUT_W-1:0] c_umax  = '1;
    localparam logic [OUT_W-1:0] c_smax  = c_umax >> 1;
    localparam logic [OUT_W-1:0] c_smin  = ~c_smax;

    logic [c_pw-1:0]  w_a_ext;
    logic [c_pw-1:0]  w_b_ext;
    logic [c_pw-1:0]  w_prod;
    logic [c_pw-1:0]  w_shift;
    logic             w_fits;
    logic [OUT_W-1:0] w_res;
    logic             w_s1_take;
    logic             w_s2_take;

    logic             r_s1_valid;
    logic [c_pw-1:0]  r_prod;
    logic             r_out_valid;
    logic [OUT_W-1:0] r_out_data;
    logic             r_out_ovf;

    generate
        if (SIGNED_A != 0) begin : g_a_sext
            assign w_a_ext = {{B_W{in_a[A_W-1]}}, in_a};
        end else begin : g_a_zext
            assign w_a_ext = {{B_W{1'b0}}, in_a};
        end

        if (SIGNED_B != 0) begin : g_b_sext
            assign w_b_ext = {{A_W{in_b[B_W-1]}}, in_b};
        end else begin : g_b_zext
            assign w_b_ext = {{A_W{1'b0}}, in_b};
        end
    endgenerate

    // Low P_W bits of the product are exact once both operands are extended.
    assign w_prod = w_a_ext * w_b_ext;

    generate
        if (c_signed) begin : g_shift_arith
            assign w_shift = $signed(r_prod) >>> SHIFT;
        end else begin : g_shift_logic
            assign w_shift = r_prod >> SHIFT;
        end

        if (OUT_W < c_pw) begin : g_fit_check
            logic w_fill;
            assign w_fill = c_signed ? w_shift[OUT_W-1] : 1'b0;
            assign w_fits = (w_shift[c_pw-1:OUT_W] == {(c_pw-OUT_W){w_fill}});
        end else begin : g_fit_full
            assign w_fits = 1'b1;
        end
    endgenerate

    always_comb begin
        w_res = w_shift[OUT_W-1:0];
        if (c_sat && !w_fits) begin
            if (!c_signed) begin
                w_res = c_umax;
            end else begin
                w_res = w_shift[c_pw-1] ? c_smin : c_smax;
            end
        end
    end

    assign w_s2_take = !r_out_valid || out_ready;
    assign w_s1_take = !r_s1_valid || w_s2_take;
    assign in_ready  = w_s1_take;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_prod      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ovf   <= 1'b0;
        end else begin
            if (w_s1_take) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_prod <= w_prod;
                end
            end
            if (w_s2_take) begin
                r_out_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_out_data <= w_res;
                    r_out_ovf  <= !w_fits;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ovf   = r_out_ovf;

endmodule
`default_nettype wire
